// File: rtl/io881_pkg.sv
// Shared io881 definitions: opcode class nibbles, packed no-op value and
// the fetch FSM state encoding.
package io881_pkg;

  localparam logic [3:0] SHORT_MAX  = 4'hB;
  localparam logic [3:0] OP0_HI     = 4'hC;
  localparam logic [3:0] OP1_HI     = 4'hD;
  localparam logic [3:0] OP2_HI     = 4'hE;
  localparam logic [3:0] JMP_HI     = 4'hF;
  localparam logic [3:0] NOP_NIBBLE = 4'h0;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_HOLD_HI,
    ST_HOLD_LO,
    ST_OPER,
    ST_ISSUE8,
    ST_SUSPEND
  } state_t;

endpackage

// File: rtl/ifetch_classify.sv
// Opcode class decode from the high nibble of a fetched byte:
// short (nibble-packed) vs 8-bit, operand byte count, jump class.
module ifetch_classify
  import io881_pkg::*;
(
  input  logic [3:0] i_hi,
  output logic       o_short,
  output logic [1:0] o_nops,
  output logic       o_jump
);

  always_comb begin
    o_short = 1'b0;
    o_nops  = 2'd0;
    o_jump  = 1'b0;
    if (i_hi <= SHORT_MAX) begin
      o_short = 1'b1;
    end else begin
      case (i_hi)
        OP0_HI:  o_nops = 2'd0;
        OP1_HI:  o_nops = 2'd1;
        OP2_HI:  o_nops = 2'd2;
        JMP_HI: begin
          o_nops = 2'd2;
          o_jump = 1'b1;
        end
        default: o_nops = 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// io881 instruction fetch: byte fetch at PC, nibble/byte instruction split,
// operand gathering and suspension after jump-class instructions.
//   state      | meaning
//   ST_RESET   | first cycle out of reset, behaves as FETCH
//   ST_FETCH   | request opcode byte at PC
//   ST_HOLD_HI | issue high nibble of a short byte
//   ST_HOLD_LO | issue low nibble of a short byte
//   ST_OPER    | fetch operand bytes following the opcode
//   ST_ISSUE8  | present 8-bit instruction with operands
//   ST_SUSPEND | wait for execute to supply the next PC
module instruction_fetch
  import io881_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic                  instr_short,
  output logic [15:0]           instr_operand,
  output logic [1:0]            instr_nops,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  suspended,
  input  logic                  resume_valid,
  input  logic [ADDR_WIDTH-1:0] resume_pc
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_ipc;
  logic [7:0]            r_byte;
  logic [15:0]           r_operand;
  logic [1:0]            r_nops;
  logic                  r_opcnt;
  logic                  r_jump;

  logic                  w_fetching;
  logic                  w_oper;
  logic                  w_ack;
  logic                  w_short;
  logic [1:0]            w_nops;
  logic                  w_jump;

  // ST_RESET requests like FETCH once reset is released, so the first
  // request appears in the very first cycle out of reset.
  assign w_fetching = (r_state == ST_FETCH) || ((r_state == ST_RESET) && !reset);
  assign w_oper     = (r_state == ST_OPER);
  assign w_ack      = mem_ack && (w_fetching || w_oper);

  ifetch_classify u_classify (
    .i_hi    (mem_data[7:4]),
    .o_short (w_short),
    .o_nops  (w_nops),
    .o_jump  (w_jump)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET, ST_FETCH: begin
        w_next = ST_FETCH;
        if (w_ack) begin
          if (w_short)             w_next = ST_HOLD_HI;
          else if (w_nops == 2'd0) w_next = ST_ISSUE8;
          else                     w_next = ST_OPER;
        end
      end
      ST_HOLD_HI: begin
        if (instr_ready) begin
          w_next = (r_byte[3:0] == NOP_NIBBLE) ? ST_FETCH : ST_HOLD_LO;
        end
      end
      ST_HOLD_LO: begin
        if (instr_ready) w_next = ST_FETCH;
      end
      ST_OPER: begin
        if (w_ack && ((r_opcnt ? 2'd2 : 2'd1) == r_nops)) w_next = ST_ISSUE8;
      end
      ST_ISSUE8: begin
        if (instr_ready) w_next = r_jump ? ST_SUSPEND : ST_FETCH;
      end
      ST_SUSPEND: begin
        if (resume_valid) w_next = ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ipc     <= '0;
      r_byte    <= '0;
      r_operand <= '0;
      r_nops    <= '0;
      r_opcnt   <= 1'b0;
      r_jump    <= 1'b0;
    end else begin
      if (w_fetching && w_ack) begin
        r_byte    <= mem_data;
        r_ipc     <= r_pc;
        r_pc      <= r_pc + ADDR_WIDTH'(1);
        r_nops    <= w_short ? 2'd0 : w_nops;
        r_jump    <= w_jump;
        r_operand <= '0;
        r_opcnt   <= 1'b0;
      end
      if (w_oper && w_ack) begin
        if (!r_opcnt) r_operand[7:0]  <= mem_data;
        else          r_operand[15:8] <= mem_data;
        r_opcnt <= 1'b1;
        r_pc    <= r_pc + ADDR_WIDTH'(1);
      end
      if ((r_state == ST_SUSPEND) && resume_valid) begin
        r_pc <= resume_pc;
      end
    end
  end

  always_comb begin
    mem_req       = w_fetching || w_oper;
    mem_addr      = (w_fetching || w_oper) ? r_pc : '0;
    instr_valid   = 1'b0;
    instr_short   = 1'b0;
    instr_opcode  = 8'h00;
    instr_operand = 16'h0000;
    instr_nops    = 2'd0;
    instr_pc      = '0;
    suspended     = (r_state == ST_SUSPEND);
    case (r_state)
      ST_HOLD_HI: begin
        instr_valid  = 1'b1;
        instr_short  = 1'b1;
        instr_opcode = {4'h0, r_byte[7:4]};
        instr_pc     = r_ipc;
      end
      ST_HOLD_LO: begin
        instr_valid  = 1'b1;
        instr_short  = 1'b1;
        instr_opcode = {4'h0, r_byte[3:0]};
        instr_pc     = r_ipc;
      end
      ST_ISSUE8: begin
        instr_valid   = 1'b1;
        instr_opcode  = r_byte;
        instr_operand = r_operand;
        instr_nops    = r_nops;
        instr_pc      = r_ipc;
      end
      default: instr_valid = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a byte memory responder, a transfer
// monitor, a table of expected issued instructions and corner-case sequences.
module tb_instruction_fetch;

  typedef struct packed {
    logic [7:0]  opc;
    logic        sh;
    logic [15:0] opr;
    logic [1:0]  nops;
    logic [15:0] pc;
  } xfer_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } prog_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic        instr_short;
  logic [15:0] instr_operand;
  logic [1:0]  instr_nops;
  logic [15:0] instr_pc;
  logic        suspended;
  logic        resume_valid = 1'b0;
  logic [15:0] resume_pc = 16'h0000;

  logic [7:0]  mem [0:65535];
  logic        mem_en = 1'b0;
  logic        spur = 1'b0;
  int          lat = 0;
  int          lat_cnt = 0;
  xfer_t       log_q[$];

  int total = 0;
  int bad = 0;

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_short   (instr_short),
    .instr_operand (instr_operand),
    .instr_nops    (instr_nops),
    .instr_pc      (instr_pc),
    .suspended     (suspended),
    .resume_valid  (resume_valid),
    .resume_pc     (resume_pc)
  );

  always #5 clk = ~clk;

  // Memory: one-cycle ack after 'lat' waiting cycles, then one idle cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        lat_cnt = 0;
      end else if (spur) begin
        mem_ack  = 1'b1;
        mem_data = 8'h5A;
        spur     = 1'b0;
      end else if (mem_req && mem_en) begin
        if (lat_cnt >= lat) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          lat_cnt  = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready)
      log_q.push_back('{instr_opcode, instr_short, instr_operand, instr_nops, instr_pc});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    total++;
    if (log_q.size() < n) begin
      bad++;
      $display("FAIL %s: timeout, got %0d transfers want %0d", nm, log_q.size(), n);
    end
  endtask

  task automatic chk_entry(input int idx, input xfer_t exp, input string nm);
    if (idx < log_q.size()) begin
      chk(nm, 64'(log_q[idx]), 64'(exp));
    end else begin
      total++;
      bad++;
      $display("FAIL %s: missing transfer %0d want %0h", nm, idx, exp);
    end
  endtask

  prog_t prog [19];
  xfer_t exp_tab [12];

  initial begin
    prog[0]  = '{16'h0000, 8'h35};
    prog[1]  = '{16'h0001, 8'h30};
    prog[2]  = '{16'h0002, 8'h4A};
    prog[3]  = '{16'h0003, 8'hD7};
    prog[4]  = '{16'h0004, 8'h42};
    prog[5]  = '{16'h0005, 8'hE1};
    prog[6]  = '{16'h0006, 8'h34};
    prog[7]  = '{16'h0007, 8'h12};
    prog[8]  = '{16'h0008, 8'h00};
    prog[9]  = '{16'h0009, 8'hC5};
    prog[10] = '{16'h000A, 8'hB1};
    prog[11] = '{16'h000B, 8'hF1};
    prog[12] = '{16'h000C, 8'h00};
    prog[13] = '{16'h000D, 8'h80};
    prog[14] = '{16'h000E, 8'hC0};
    prog[15] = '{16'hFFFE, 8'hE2};
    prog[16] = '{16'hFFFF, 8'hAA};
    prog[17] = '{16'h8000, 8'hC3};
    prog[18] = '{16'h8001, 8'hC4};

    exp_tab[0]  = '{8'h03, 1'b1, 16'h0000, 2'd0, 16'h0000};
    exp_tab[1]  = '{8'h05, 1'b1, 16'h0000, 2'd0, 16'h0000};
    exp_tab[2]  = '{8'h03, 1'b1, 16'h0000, 2'd0, 16'h0001};
    exp_tab[3]  = '{8'h04, 1'b1, 16'h0000, 2'd0, 16'h0002};
    exp_tab[4]  = '{8'h0A, 1'b1, 16'h0000, 2'd0, 16'h0002};
    exp_tab[5]  = '{8'hD7, 1'b0, 16'h0042, 2'd1, 16'h0003};
    exp_tab[6]  = '{8'hE1, 1'b0, 16'h1234, 2'd2, 16'h0005};
    exp_tab[7]  = '{8'h00, 1'b1, 16'h0000, 2'd0, 16'h0008};
    exp_tab[8]  = '{8'hC5, 1'b0, 16'h0000, 2'd0, 16'h0009};
    exp_tab[9]  = '{8'h0B, 1'b1, 16'h0000, 2'd0, 16'h000A};
    exp_tab[10] = '{8'h01, 1'b1, 16'h0000, 2'd0, 16'h000A};
    exp_tab[11] = '{8'hF1, 1'b0, 16'h8000, 2'd2, 16'h000B};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hC0;
    for (int i = 0; i < 19; i++) mem[prog[i].addr] = prog[i].data;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_suspended", 64'(suspended), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_opcode", 64'(instr_opcode), 64'd0);

    // Startup without ack; stray resume ignored
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("start_req", 64'(mem_req), 64'd1);
      chk("start_addr", 64'(mem_addr), 64'h0000);
      chk("start_valid", 64'(instr_valid), 64'd0);
      @(posedge clk); #1;
      resume_valid = (i == 1);
      resume_pc    = 16'h1234;
    end
    @(negedge clk);
    chk("resume_ignored_addr", 64'(mem_addr), 64'h0000);
    chk("resume_ignored_susp", 64'(suspended), 64'd0);

    // Linear program through to the jump
    @(posedge clk); #1;
    mem_en = 1'b1;
    lat = 0;
    instr_ready = 1'b1;
    begin
      int c = 0;
      while (!suspended && c < 400) begin
        @(negedge clk);
        c++;
      end
    end
    chk("suspend_entry", 64'(suspended), 64'd1);
    chk("prog_count", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk_entry(i, exp_tab[i], $sformatf("prog_xfer%0d", i));

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) spur = 1'b1;
      @(negedge clk);
      chk("susp_hold", 64'(suspended), 64'd1);
      chk("susp_no_req", 64'(mem_req), 64'd0);
    end
    chk("susp_no_issue", 64'(log_q.size()), 64'd12);

    // Resume, operand fetch wrapping past 0xFFFF
    @(posedge clk); #1;
    resume_valid = 1'b1;
    resume_pc    = 16'hFFFE;
    @(posedge clk); #1;
    resume_valid = 1'b0;
    @(negedge clk);
    chk("resume_req", 64'(mem_req), 64'd1);
    chk("resume_addr", 64'(mem_addr), 64'hFFFE);
    chk("resume_susp", 64'(suspended), 64'd0);
    wait_log(13, 50, "wrap_wait");
    chk_entry(12, '{8'hE2, 1'b0, 16'h35AA, 2'd2, 16'hFFFE}, "wrap_xfer");
    @(negedge clk);
    chk("wrap_next_req", 64'(mem_req), 64'd1);
    chk("wrap_next_addr", 64'(mem_addr), 64'h0001);

    // Backpressure on a short byte
    @(posedge clk); #1;
    reset = 1'b1;
    instr_ready = 1'b0;
    lat = 2;
    repeat (2) @(posedge clk);
    #1;
    log_q.delete();
    reset = 1'b0;
    begin
      int c = 0;
      while (!instr_valid && c < 50) begin
        @(negedge clk);
        c++;
      end
    end
    chk("bp_valid", 64'(instr_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_opcode", 64'(instr_opcode), 64'h03);
      chk("bp_short", 64'(instr_short), 64'd1);
      chk("bp_pc", 64'(instr_pc), 64'h0000);
      chk("bp_no_req", 64'(mem_req), 64'd0);
    end
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_log(2, 20, "bp_wait");
    chk_entry(0, exp_tab[0], "bp_xfer0");
    chk_entry(1, exp_tab[1], "bp_xfer1");
    @(negedge clk);
    chk("bp_next_req", 64'(mem_req), 64'd1);
    chk("bp_next_addr", 64'(mem_addr), 64'h0001);
    mem_en = 1'b0;

    // Reset during an outstanding request with a stray ack inside reset
    @(posedge clk); #1;
    reset = 1'b1;
    spur  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    log_q.delete();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 64'(mem_req), 64'd1);
    chk("mid_rst_addr", 64'(mem_addr), 64'h0000);
    chk("mid_rst_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("mid_rst_no_issue", 64'(log_q.size()), 64'd0);
    chk("mid_rst_addr2", 64'(mem_addr), 64'h0000);
    mem_en = 1'b1;
    wait_log(1, 30, "mid_rst_wait");
    chk_entry(0, exp_tab[0], "mid_rst_xfer");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
